// File: rtl/sram_session_arbiter.sv
// Loader session FSM with a round-robin read arbiter sharing one SRAM port.
// Optional SESSION_CHECKSUM_EN builds a running sum of counted loader writes.
module sram_session_arbiter #(
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_READERS    = 2,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_WIDTH    = 26
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic                              Start,
  input  logic                              Rx_line,
  input  logic [ADDR_WIDTH-1:0]             Loader_address,
  input  logic [DATA_WIDTH-1:0]             Loader_write_data,
  input  logic                              Loader_we_n,
  output logic                              Loader_initialize,
  output logic                              Loader_enable,
  input  logic [NUM_READERS-1:0]            Reader_req,
  input  logic [NUM_READERS*ADDR_WIDTH-1:0] Reader_address,
  output logic [NUM_READERS-1:0]            Reader_grant,
  output logic [ADDR_WIDTH-1:0]             SRAM_address,
  output logic [DATA_WIDTH-1:0]             SRAM_write_data,
  output logic                              SRAM_we_n,
  output logic                              Display_enable,
  output logic [ADDR_WIDTH-1:0]             Words_written,
  output logic [DATA_WIDTH-1:0]             Checksum,
  output logic [1:0]                        State
);

  localparam int PTR_W = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
  localparam logic [TIMER_WIDTH-1:0] TMAX = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0]  WMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENABLE = 2'd1,
    S_WAIT   = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     init_q, init_d;
  logic                     en_q, en_d;
  logic                     disp_q, disp_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic [ADDR_WIDTH-1:0]    words_q, words_d;
  logic [NUM_READERS-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     in_session, clr_session, wr_inc, timeout;

  logic [NUM_READERS-1:0][ADDR_WIDTH-1:0] rd_addr;

  for (genvar g = 0; g < NUM_READERS; g++) begin : g_unpack
    assign rd_addr[g] = Reader_address[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign in_session = (state_q == S_ENABLE) || (state_q == S_WAIT);
  // Writes past saturation are neither counted nor summed.
  assign wr_inc     = (state_q == S_WAIT) && !Loader_we_n && (words_q != WMAX);
  assign timeout    = (timer_q == TMAX) && (words_q != '0) && Loader_we_n;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      en_q    <= 1'b0;
      disp_q  <= 1'b1;
      timer_q <= '0;
      words_q <= '0;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_READERS - 1);
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      en_q    <= en_d;
      disp_q  <= disp_d;
      timer_q <= timer_d;
      words_q <= words_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= SRAM_address;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_d      = 1'b0;
    en_d        = 1'b0;
    disp_d      = disp_q;
    clr_session = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Rx_line || Start) begin
          state_d     = S_ENABLE;
          init_d      = 1'b1;
          disp_d      = 1'b0;
          clr_session = 1'b1;
        end
      end
      S_ENABLE: begin
        state_d = S_WAIT;
        en_d    = 1'b1;
      end
      S_WAIT: begin
        if (timeout) begin
          state_d = S_FLUSH;
          init_d  = 1'b1;
          disp_d  = 1'b1;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (init_q || (in_session && !Loader_we_n)) timer_d = '0;
    else if (timer_q != TMAX)                   timer_d = timer_q + 1'b1;
  end

  always_comb begin
    words_d = words_q;
    if (clr_session) words_d = '0;
    else if (wr_inc) words_d = words_q + 1'b1;
  end

  // Arbitrate on the next state so no grant leaks into a session's first cycle.
  always_comb begin
    logic found;
    int   idx;
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    if (state_d == S_IDLE || state_d == S_FLUSH) begin
      for (int k = 1; k <= NUM_READERS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_READERS) idx = idx - NUM_READERS;
        if (!found && Reader_req[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          ptr_d        = PTR_W'(idx);
        end
      end
    end
  end

  // ptr_q always names the current grantee while a grant is live.
  always_comb begin
    SRAM_address = addr_q;
    if (in_session)    SRAM_address = Loader_address;
    else if (|grant_q) SRAM_address = rd_addr[ptr_q];
  end

  assign SRAM_we_n         = in_session ? Loader_we_n : 1'b1;
  assign SRAM_write_data   = Loader_write_data;
  assign Reader_grant      = grant_q;
  assign Loader_initialize = init_q;
  assign Loader_enable     = en_q;
  assign Display_enable    = disp_q;
  assign Words_written     = words_q;
  assign State             = state_q;

`ifdef SESSION_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr_session) csum_d = '0;
    else if (wr_inc) csum_d = csum_q + Loader_write_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign Checksum = csum_q;
`else
  assign Checksum = '0;
`endif

endmodule

// File: tb/tb_sram_session_arbiter.sv
// Directed bench for sram_session_arbiter (3 readers, 16-cycle timeout).
module tb_sram_session_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int NR = 3;

  logic          Clock = 1'b0;
  logic          Reset, Start, Rx_line, Loader_we_n;
  logic [AW-1:0] Loader_address;
  logic [DW-1:0] Loader_write_data;
  logic          Loader_initialize, Loader_enable;
  logic [NR-1:0] Reader_req, Reader_grant;
  logic [NR*AW-1:0] Reader_address;
  logic [AW-1:0] SRAM_address, Words_written;
  logic [DW-1:0] SRAM_write_data, Checksum;
  logic          SRAM_we_n, Display_enable;
  logic [1:0]    State;

  int n_chk = 0;
  int n_fail = 0;

  sram_session_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READERS(NR),
    .TIMEOUT_CYCLES(16), .TIMER_WIDTH(5)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rx_line(Rx_line),
    .Loader_address(Loader_address), .Loader_write_data(Loader_write_data),
    .Loader_we_n(Loader_we_n), .Loader_initialize(Loader_initialize),
    .Loader_enable(Loader_enable), .Reader_req(Reader_req),
    .Reader_address(Reader_address), .Reader_grant(Reader_grant),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Display_enable(Display_enable),
    .Words_written(Words_written), .Checksum(Checksum), .State(State)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Rx_line = 1'b1; Loader_we_n = 1'b1;
    Loader_address = '0; Loader_write_data = '0; Reader_req = '0; Reader_address = '0;
    tick(); tick();
    Reset = 1'b0;
    tick();
  endtask

  // Opens a session and returns with State in S_WAIT.
  task automatic open_session();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Rx_line = 1'b1; Loader_we_n = 1'b1;
    Loader_address = '0; Loader_write_data = '0; Reader_req = '0; Reader_address = '0;
    #3;
    n_chk++; if (State !== 2'd0) begin n_fail++; $display("FAIL reset_state act=%0d exp=0", State); end
    n_chk++; if (Display_enable !== 1'b1) begin n_fail++; $display("FAIL reset_display act=%b exp=1", Display_enable); end
    n_chk++; if ({Loader_initialize, Loader_enable} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses act=%b exp=00", {Loader_initialize, Loader_enable}); end
    n_chk++; if (Reader_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant act=%b exp=000", Reader_grant); end
    n_chk++; if (SRAM_we_n !== 1'b1 || SRAM_address !== '0) begin n_fail++; $display("FAIL reset_sram we_n=%b addr=%h exp 1/0", SRAM_we_n, SRAM_address); end
    n_chk++; if (Words_written !== '0 || Checksum !== '0) begin n_fail++; $display("FAIL reset_counts words=%0d csum=%h exp 0/0", Words_written, Checksum); end
    tick();
    Reset = 1'b0;
    tick();
    Loader_we_n = 1'b0;
    #1;
    n_chk++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL idle_we_ignored act=%b exp=1", SRAM_we_n); end
    tick();
    Loader_we_n = 1'b1;
    n_chk++; if (State !== 2'd0 || Words_written !== '0) begin n_fail++; $display("FAIL idle_write_state st=%0d words=%0d exp 0/0", State, Words_written); end
  endtask

  task automatic test_start();
    do_reset();
    Reader_req = 3'b111;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_chk++; if (State !== 2'd1) begin n_fail++; $display("FAIL start_state1 act=%0d exp=1", State); end
    n_chk++; if ({Loader_initialize, Loader_enable} !== 2'b10) begin n_fail++; $display("FAIL start_init act=%b exp=10", {Loader_initialize, Loader_enable}); end
    n_chk++; if (Display_enable !== 1'b0) begin n_fail++; $display("FAIL start_display act=%b exp=0", Display_enable); end
    n_chk++; if (Reader_grant !== 3'b000) begin n_fail++; $display("FAIL start_grant act=%b exp=000", Reader_grant); end
    tick();
    n_chk++; if (State !== 2'd2) begin n_fail++; $display("FAIL start_state2 act=%0d exp=2", State); end
    n_chk++; if ({Loader_initialize, Loader_enable} !== 2'b01) begin n_fail++; $display("FAIL start_enable act=%b exp=01", {Loader_initialize, Loader_enable}); end
    Loader_address = 18'h2AAAA;
    tick();
    n_chk++; if (Loader_enable !== 1'b0) begin n_fail++; $display("FAIL start_enable_end act=%b exp=0", Loader_enable); end
    n_chk++; if (SRAM_address !== 18'h2AAAA || SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL session_mux addr=%h we_n=%b exp 2aaaa/1", SRAM_address, SRAM_we_n); end
    n_chk++; if (Reader_grant !== 3'b000) begin n_fail++; $display("FAIL session_grant act=%b exp=000", Reader_grant); end
    Reader_req = '0;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] exp_cs;
`ifdef SESSION_CHECKSUM_EN
    exp_cs = 16'h1234;
`else
    exp_cs = 16'h0000;
`endif
    do_reset();
    Start = 1'b1; Rx_line = 1'b0;
    tick();
    Start = 1'b0; Rx_line = 1'b1;
    n_chk++; if (State !== 2'd1) begin n_fail++; $display("FAIL dual_open_state act=%0d exp=1", State); end
    tick();
    Loader_we_n = 1'b0;
    Loader_write_data = 16'h1234; tick();
    Loader_write_data = 16'h0001; tick();
    Loader_write_data = 16'hFFFF;
    #1;
    n_chk++; if (SRAM_we_n !== 1'b0 || SRAM_write_data !== 16'hFFFF) begin n_fail++; $display("FAIL write_mux we_n=%b data=%h exp 0/ffff", SRAM_we_n, SRAM_write_data); end
    tick();
    Loader_we_n = 1'b1;
    n_chk++; if (Words_written !== 18'd3) begin n_fail++; $display("FAIL words3 act=%0d exp=3", Words_written); end
    for (int i = 0; i < 15; i++) begin
      Start = (i == 5);
      Rx_line = (i != 7);
      tick();
    end
    Start = 1'b0; Rx_line = 1'b1;
    n_chk++; if (State !== 2'd2) begin n_fail++; $display("FAIL pre_timeout_state act=%0d exp=2", State); end
    tick();
    n_chk++; if (State !== 2'd3) begin n_fail++; $display("FAIL flush_state act=%0d exp=3", State); end
    n_chk++; if (Loader_initialize !== 1'b1 || Display_enable !== 1'b1) begin n_fail++; $display("FAIL flush_outputs init=%b disp=%b exp 1/1", Loader_initialize, Display_enable); end
    n_chk++; if (Checksum !== exp_cs) begin n_fail++; $display("FAIL checksum act=%h exp=%h", Checksum, exp_cs); end
    tick();
    n_chk++; if (State !== 2'd0 || Loader_initialize !== 1'b0) begin n_fail++; $display("FAIL post_flush st=%0d init=%b exp 0/0", State, Loader_initialize); end
    n_chk++; if (Words_written !== 18'd3 || Checksum !== exp_cs || Display_enable !== 1'b1) begin n_fail++; $display("FAIL post_flush_hold words=%0d csum=%h disp=%b exp 3/%h/1", Words_written, Checksum, Display_enable, exp_cs); end
  endtask

  task automatic test_no_writes();
    do_reset();
    open_session();
    for (int i = 0; i < 100; i++) tick();
    n_chk++; if (State !== 2'd2) begin n_fail++; $display("FAIL nowrite_state act=%0d exp=2", State); end
    n_chk++; if (dut.timer_q !== 5'd15) begin n_fail++; $display("FAIL nowrite_timer act=%0d exp=15", dut.timer_q); end
  endtask

  task automatic test_round_robin();
    do_reset();
    Reader_address = {18'h00033, 18'h00022, 18'h00011};
    Reader_req = 3'b111;
    #1;
    n_chk++; if (Reader_grant !== 3'b000) begin n_fail++; $display("FAIL rr_latency act=%b exp=000", Reader_grant); end
    tick();
    n_chk++; if (Reader_grant !== 3'b001 || SRAM_address !== 18'h00011) begin n_fail++; $display("FAIL rr_g0 grant=%b addr=%h exp 001/00011", Reader_grant, SRAM_address); end
    tick();
    n_chk++; if (Reader_grant !== 3'b010 || SRAM_address !== 18'h00022) begin n_fail++; $display("FAIL rr_g1 grant=%b addr=%h exp 010/00022", Reader_grant, SRAM_address); end
    tick();
    n_chk++; if (Reader_grant !== 3'b100 || SRAM_address !== 18'h00033) begin n_fail++; $display("FAIL rr_g2 grant=%b addr=%h exp 100/00033", Reader_grant, SRAM_address); end
    tick();
    n_chk++; if (Reader_grant !== 3'b001 || SRAM_address !== 18'h00011) begin n_fail++; $display("FAIL rr_wrap grant=%b addr=%h exp 001/00011", Reader_grant, SRAM_address); end
    Reader_req = 3'b000;
    tick();
    n_chk++; if (Reader_grant !== 3'b000 || SRAM_address !== 18'h00011) begin n_fail++; $display("FAIL rr_none grant=%b addr=%h exp 000/00011", Reader_grant, SRAM_address); end
    Reader_req = 3'b100;
    tick();
    n_chk++; if (Reader_grant !== 3'b100 || SRAM_address !== 18'h00033) begin n_fail++; $display("FAIL rr_single grant=%b addr=%h exp 100/00033", Reader_grant, SRAM_address); end
    Reader_req = 3'b000;
  endtask

  task automatic test_reset_mid_session();
    int init_seen;
    do_reset();
    open_session();
    Loader_we_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Loader_write_data = 16'(i + 1);
      tick();
    end
    n_chk++; if (Words_written !== 18'd5) begin n_fail++; $display("FAIL mid_words5 act=%0d exp=5", Words_written); end
    Reset = 1'b1;
    #1;
    n_chk++; if (State !== 2'd0 || SRAM_we_n !== 1'b1 || Words_written !== '0) begin n_fail++; $display("FAIL mid_reset st=%0d we_n=%b words=%0d exp 0/1/0", State, SRAM_we_n, Words_written); end
    init_seen = 0;
    tick();
    Reset = 1'b0; Loader_we_n = 1'b1;
    #1;
    if (Loader_initialize) init_seen++;
    tick();
    n_chk++; if (State !== 2'd0) begin n_fail++; $display("FAIL mid_release_state act=%0d exp=0", State); end
    for (int i = 0; i < 4; i++) begin
      if (Loader_initialize) init_seen++;
      tick();
    end
    n_chk++; if (init_seen !== 0) begin n_fail++; $display("FAIL mid_no_flush act=%0d exp=0", init_seen); end
  endtask

  task automatic test_write_on_timeout();
    logic [DW-1:0] exp_cs;
`ifdef SESSION_CHECKSUM_EN
    exp_cs = 16'h0105;
`else
    exp_cs = 16'h0000;
`endif
    do_reset();
    open_session();
    Loader_we_n = 1'b0; Loader_write_data = 16'h0100;
    tick();
    Loader_we_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    n_chk++; if (dut.timer_q !== 5'd15 || State !== 2'd2) begin n_fail++; $display("FAIL tw_at_timeout timer=%0d st=%0d exp 15/2", dut.timer_q, State); end
    Loader_we_n = 1'b0; Loader_write_data = 16'h0005;
    tick();
    Loader_we_n = 1'b1;
    n_chk++; if (State !== 2'd2 || Words_written !== 18'd2) begin n_fail++; $display("FAIL tw_stay st=%0d words=%0d exp 2/2", State, Words_written); end
    n_chk++; if (dut.timer_q !== 5'd0) begin n_fail++; $display("FAIL tw_timer_clr act=%0d exp=0", dut.timer_q); end
    for (int i = 0; i < 15; i++) tick();
    n_chk++; if (State !== 2'd2) begin n_fail++; $display("FAIL tw_wait_again act=%0d exp=2", State); end
    tick();
    n_chk++; if (State !== 2'd3 || Checksum !== exp_cs) begin n_fail++; $display("FAIL tw_flush st=%0d csum=%h exp 3/%h", State, Checksum, exp_cs); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_timeout();
    test_no_writes();
    test_round_robin();
    test_reset_mid_session();
    test_write_on_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_session_arbiter.md
SRAM_SESSION_ARBITER -- requirements
Module: sram_session_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 18, SRAM address width.
- DATA_WIDTH, 16, SRAM data width.
- NUM_READERS, 2, read clients (1..8).
- TIMEOUT_CYCLES, 50000000, idle cycles that end a load session.
- TIMER_WIDTH, 26, timer width; must hold TIMEOUT_CYCLES-1.

REQ-002 Ports (name, direction, width, meaning):
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle session request (pushbutton).
- Rx_line  in  1  UART line; low = activity.
- Loader_address  in  ADDR_WIDTH  loader write address.
- Loader_write_data  in  DATA_WIDTH  loader write data.
- Loader_we_n  in  1  loader write strobe, active-low.
- Loader_initialize  out  1  loader clear pulse.
- Loader_enable  out  1  loader start pulse.
- Reader_req  in  NUM_READERS  read requests.
- Reader_address  in  NUM_READERS*ADDR_WIDTH  packed read addresses; reader i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- Reader_grant  out  NUM_READERS  one-hot grant.
- SRAM_address  out  ADDR_WIDTH  to SRAM controller.
- SRAM_write_data  out  DATA_WIDTH  to SRAM controller.
- SRAM_we_n  out  1  to SRAM controller.
- Display_enable  out  1  high when readers may own SRAM.
- Words_written  out  ADDR_WIDTH  writes in current or last session.
- Checksum  out  DATA_WIDTH  session checksum.
- State  out  2  current FSM state code.

Function
REQ-003 FSM states and codes: S_IDLE=0, S_ENABLE=1, S_WAIT=2, S_FLUSH=3.
REQ-004 S_IDLE: Rx_line==0 or Start==1 -> S_ENABLE. Same edge: Loader_initialize=1, Display_enable=0, Words_written=0, Checksum=0.
REQ-005 S_ENABLE: Loader_enable=1 for one cycle -> S_WAIT.
REQ-006 S_WAIT: timeout when timer == TIMEOUT_CYCLES-1, Words_written != 0 and Loader_we_n==1 -> S_FLUSH.
REQ-007 S_FLUSH: Loader_initialize=1 for one cycle, Display_enable=1 -> S_IDLE.
REQ-008 Timer: cleared on cycles with Loader_initialize==1 or Loader_we_n==0; otherwise increments; saturates at TIMEOUT_CYCLES-1 (never wraps).
REQ-009 Outputs are muxed by session:
- In S_ENABLE or S_WAIT: SRAM_address=Loader_address, SRAM_we_n=Loader_we_n, Reader_grant=0.
- Otherwise: SRAM_we_n=1.
- SRAM_write_data=Loader_write_data always.
REQ-010 Words_written increments on each S_WAIT cycle with Loader_we_n==0; saturates at 2^ADDR_WIDTH-1.
REQ-011 Reader arbitration:
- Active only in S_IDLE and S_FLUSH.
- Registered round-robin grant: a request asserted at cycle n is granted at n+1 at the earliest.
- Search starts at the index after the last grantee; the lowest-index requester wins when none was granted before.
- Grant re-evaluated every cycle; no requests -> Reader_grant=0.
REQ-012 When Reader_grant is nonzero, SRAM_address = Reader_address of the granted reader. When zero, SRAM_address holds its last value.
REQ-013 Start or Rx_line activity outside S_IDLE is ignored. Loader_we_n==0 outside S_ENABLE/S_WAIT is ignored.
REQ-014 Start and Rx_line activity in the same cycle open exactly one session.
REQ-015 A write on the timeout cycle wins: the timer clears and the FSM stays in S_WAIT.

Reset
REQ-016 Reset=1 asynchronously forces:
- State=S_IDLE, Display_enable=1.
- Loader_initialize=0, Loader_enable=0.
- Reader_grant=0, round-robin pointer=NUM_READERS-1.
- Timer, Words_written, Checksum, SRAM_address = 0.
- SRAM_we_n=1.
REQ-017 Reset during S_WAIT aborts the session with no S_FLUSH pulse. The first cycle after release is S_IDLE.

Configuration
REQ-018 Macro SESSION_CHECKSUM_EN:
- Defined: Checksum = modulo-2^DATA_WIDTH sum of Loader_write_data over counted writes (REQ-010), cleared as in REQ-004. It holds after the session ends.
- Undefined: Checksum is constant 0 and no adder is built.

Verification
REQ-019 Start pulse in S_IDLE -> Loader_initialize high one cycle, then Loader_enable high one cycle, State 0->1->2, Display_enable=0.
REQ-020 TIMEOUT_CYCLES=16 test parameter, three writes 0x1234, 0x0001, 0xFFFF, then silence:
- S_FLUSH entered 16 cycles after the last write.
- Words_written=3; Checksum=0x1234 with SESSION_CHECKSUM_EN defined, 0 without.
- Display_enable=1.
REQ-021 Session with no writes for 100 cycles (TIMEOUT_CYCLES=16) -> stays in S_WAIT, timer held at 15.
REQ-022 NUM_READERS=3, all Reader_req high in S_IDLE -> Reader_grant cycles 001, 010, 100, 001. SRAM_address follows each grantee's address one cycle later.
REQ-023 Reset asserted mid-S_WAIT after 5 writes:
- Immediately: State=0, SRAM_we_n=1, Words_written=0.
- No Loader_initialize pulse is seen.
REQ-024 Loader_we_n=0 on the exact timeout cycle -> no transition, Words_written increments, timer restarts from 0.
